// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for the EX stage: DIV/DIVU with a fixed
// 33-cycle latency, a one-cycle result strobe and a pipeline stall request.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             div_valid_i,
  input  logic             div_signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             ready_o,
  output logic             div_stall_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  logic [1:0]       state;
  logic [5:0]       step_cnt;
  logic [WIDTH:0]   rem_acc;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] dvs_mag;
  logic             quo_neg;
  logic             rem_neg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // Magnitude of a two's complement value; the most negative value wraps to itself,
  // which is still the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] neg_v;
    neg_v = -v;
    return v[WIDTH-1] ? WIDTH'(neg_v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    return neg ? (~mag + WIDTH'(1)) : mag;
  endfunction

  // One restoring step: bring in the next dividend bit, keep the difference if it
  // did not borrow, and record the outcome as the next quotient bit.
  always_comb begin
    shifted  = {rem_acc[WIDTH-1:0], quo_acc[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_mag};
    rem_next = shifted;
    quo_next = {quo_acc[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial;
      quo_next = {quo_acc[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      step_cnt <= '0;
      rem_acc  <= '0;
      quo_acc  <= '0;
      dvs_mag  <= '0;
      quo_neg  <= 1'b0;
      rem_neg  <= 1'b0;
    end else if (annul_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid_i) begin
            state    <= BUSY;
            step_cnt <= '0;
            rem_acc  <= '0;
            if (div_signed_i) begin
              quo_acc <= abs_val(dividend_i);
              dvs_mag <= abs_val(divisor_i);
              quo_neg <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
              rem_neg <= dividend_i[WIDTH-1];
            end else begin
              quo_acc <= dividend_i;
              dvs_mag <= divisor_i;
              quo_neg <= 1'b0;
              rem_neg <= 1'b0;
            end
          end
        end
        BUSY: begin
          rem_acc  <= rem_next;
          quo_acc  <= quo_next;
          step_cnt <= step_cnt + 6'd1;
          if (step_cnt == LAST_STEP) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Results are only driven during the strobe so downstream muxing can simply OR them.
  always_comb begin
    ready_o = (state == DONE);
    lo_o    = '0;
    hi_o    = '0;
    if (ready_o) begin
      lo_o = apply_sign(quo_acc, quo_neg);
      hi_o = apply_sign(rem_acc[WIDTH-1:0], rem_neg);
    end
  end

  assign div_stall_o = div_valid_i & ~ready_o & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// overflow wrap, annul, mid-operation reset and back-to-back issue.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid;
  logic        div_signed;
  logic        annul;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ready;
  logic        div_stall;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .div_valid_i  (div_valid),
    .div_signed_i (div_signed),
    .annul_i      (annul),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .hi_o         (hi),
    .lo_o         (lo),
    .ready_o      (ready),
    .div_stall_o  (div_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move into the next cycle: inputs change 2 time units after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Issues a division in the next cycle (cycle 0) and follows it to the strobe in
  // cycle 33; operands are scrambled mid-operation while valid stays high.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    next_cycle();
    div_valid = 1'b1; div_signed = sgn; dividend = a; divisor = b;
    #1;
    chk({tag, " stall c0"}, 32'(div_stall), 32'd1);
    chk({tag, " ready c0"}, 32'(ready), 32'd0);
    for (int c = 1; c <= 32; c++) begin
      next_cycle();
      if (c == 3) begin
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0001;
      end
      #1;
      chk($sformatf("%s ready c%0d", tag, c), 32'(ready), 32'd0);
      chk($sformatf("%s stall c%0d", tag, c), 32'(div_stall), 32'd1);
      chk($sformatf("%s lo c%0d", tag, c), lo, 32'd0);
    end
    next_cycle();
    #1;
    chk({tag, " ready c33"}, 32'(ready), 32'd1);
    chk({tag, " stall c33"}, 32'(div_stall), 32'd0);
    chk({tag, " lo"}, lo, exp_lo);
    chk({tag, " hi"}, hi, exp_hi);
  endtask

  task automatic go_idle(input string tag);
    next_cycle();
    div_valid = 1'b0;
    #1;
    chk({tag, " ready idle"}, 32'(ready), 32'd0);
    chk({tag, " lo idle"}, lo, 32'd0);
    chk({tag, " hi idle"}, hi, 32'd0);
  endtask

  initial begin
    rst = 1'b1; div_valid = 1'b0; div_signed = 1'b0; annul = 1'b0;
    dividend = '0; divisor = '0;
    next_cycle();
    next_cycle();
    #1;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset stall", 32'(div_stall), 32'd0);
    rst = 1'b0;
    next_cycle();

    // Basic unsigned and signed quotients/remainders
    run_div("divu 7/2", 1'b0, 32'd7, 32'd2, 32'd3, 32'd1);
    go_idle("divu 7/2");
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    go_idle("div -7/2");
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    go_idle("div 7/-2");

    // Divide by zero and the signed overflow case
    run_div("divu x/0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    go_idle("divu x/0");
    run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB);
    go_idle("div -5/0");
    run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    go_idle("div min/-1");

    // Annul at cycle 10, idle cycle 11, new DIVU issued at cycle 12
    next_cycle();
    div_valid = 1'b1; div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 10) annul = 1'b1;
    end
    #1;
    chk("annul stall", 32'(div_stall), 32'd0);
    next_cycle();
    annul = 1'b0; div_valid = 1'b0;
    #1;
    chk("annul ready c11", 32'(ready), 32'd0);
    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    go_idle("divu 100/7");

    // Reset at cycle 20 of a signed division
    next_cycle();
    div_valid = 1'b1; div_signed = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd3;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      if (c == 20) rst = 1'b1;
    end
    #1;
    chk("stall in reset", 32'(div_stall), 32'd1);
    next_cycle();
    rst = 1'b0; div_valid = 1'b0;
    #1;
    chk("post-reset ready", 32'(ready), 32'd0);
    chk("post-reset lo", lo, 32'd0);
    chk("post-reset hi", hi, 32'd0);
    chk("post-reset stall", 32'(div_stall), 32'd0);
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      #1;
      chk($sformatf("no ready after reset %0d", c), 32'(ready), 32'd0);
    end

    // Back-to-back: second division issued the cycle after the first strobe
    run_div("b2b 9/4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);
    run_div("b2b 15/4", 1'b0, 32'd15, 32'd4, 32'd3, 32'd3);
    go_idle("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL: parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL: clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL: rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL: div_valid_i  input  1  EX-stage instruction is DIV/DIVU; held high while EX is stalled.
REQ-005 SHALL: div_signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 SHALL: annul_i  input  1  EX flush / exception in MEM; aborts any operation.
REQ-007 SHALL: dividend_i  input  32  rs operand (reg1).
REQ-008 SHALL: divisor_i  input  32  rt operand (reg2).
REQ-009 SHALL: hi_o  output  32  remainder, valid when ready_o=1.
REQ-010 SHALL: lo_o  output  32  quotient, valid when ready_o=1.
REQ-011 SHALL: ready_o  output  1  single-cycle result-valid strobe.
REQ-012 SHALL: div_stall_o  output  1  stall request to the pipeline hazard unit.

Function
REQ-013 SHALL: FSM with states IDLE, BUSY, DONE.
REQ-014 SHALL: in IDLE, div_valid_i=1 and annul_i=0 transitions to BUSY.
- Latch |dividend| and |divisor| (signed mode) or the raw values (unsigned mode).
- Latch quotient sign = dividend[31]^divisor[31] and remainder sign = dividend[31] (signed mode only).
- Clear the 6-bit iteration counter.
REQ-015 SHALL: BUSY performs one restoring radix-2 step per cycle on a 33-bit partial remainder: shift left, trial-subtract the divisor, set the quotient bit if the result is non-negative; exactly 32 steps.
REQ-016 SHALL: after the 32nd step (counter = 31), transition BUSY -> DONE.
REQ-017 SHALL: in DONE, assert ready_o for exactly one cycle and present sign-corrected results; next state is IDLE unconditionally.
REQ-018 SHALL: in DONE, lo_o = quotient negated if quotient sign = 1; hi_o = remainder negated if remainder sign = 1.
REQ-019 SHALL: latency is fixed: div_valid_i first sampled in cycle N -> ready_o=1 in cycle N+33.
REQ-020 SHALL: div_stall_o = div_valid_i & ~ready_o & ~annul_i (combinational), so EX advances in the DONE cycle.
REQ-021 SHALL: div_valid_i is ignored in DONE; a new division starts only from IDLE, i.e. back-to-back DIVs start one cycle after the previous DONE.
REQ-022 SHALL: divisor = 0 follows the same 33-cycle path, giving the natural restoring result:
- unsigned: lo_o=0xFFFFFFFF, hi_o=dividend;
- signed: sign correction as in REQ-018.
- No exception is raised.
REQ-023 SHALL: 0x80000000 / 0xFFFFFFFF in signed mode yields lo_o=0x80000000, hi_o=0 (32-bit wrap, no trap).
REQ-024 SHALL: annul_i=1 in any state forces IDLE on the next edge, with no ready_o pulse for the aborted operation; annul_i has priority over the start in REQ-014.
REQ-025 SHALL: operand inputs changing during BUSY have no effect on the result.
REQ-026 SHALL: hi_o and lo_o read 0 whenever ready_o=0.

Reset
REQ-027 SHALL: rst_i=1 at an edge forces IDLE, clears the counter and all datapath registers; ready_o=0, hi_o=0, lo_o=0.
REQ-028 SHALL: reset mid-BUSY discards the operation; no ready_o pulse follows.
REQ-029 SHALL: while rst_i=1, div_stall_o follows REQ-020 combinationally; the pipeline reset masks it.

Verification
REQ-030 SHALL: DIVU 7/2, valid at cycle 0 -> ready_o=1 at cycle 33, lo_o=3, hi_o=1; div_stall_o=1 in cycles 0-32 and 0 in cycle 33.
REQ-031 SHALL: DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 7/-2 -> lo_o=0xFFFFFFFD, hi_o=1.
REQ-032 SHALL: DIVU 0x12345678/0 -> lo_o=0xFFFFFFFF, hi_o=0x12345678 at cycle 33; DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-033 SHALL: annul_i pulsed at cycle 10 of a DIVU -> IDLE at cycle 11, no ready_o; a new DIVU 100/7 started at cycle 12 -> ready_o at cycle 45, lo_o=14, hi_o=2.
REQ-034 SHALL: rst_i asserted at cycle 20 of a DIV -> all outputs 0 next cycle, no ready_o within 40 cycles with div_valid_i=0.
REQ-035 SHALL: two back-to-back DIVUs (9/4, then 15/4) -> first ready_o at cycle 33 (lo_o=2, hi_o=1), second started at cycle 34, ready_o at cycle 67 (lo_o=3, hi_o=3).
